// File: rtl/mprj_checkpoint_monitor_if.sv
// Signal bundle between the checkpoint monitor and whatever drives or observes it.
//
// Protocol: there is no valid/ready pair. code_valid is a one-cycle qualifier
// for code. The monitor never stalls, so a consumer that needs every filtered
// code must sample code on the cycle that code_valid is high. done/pass/fail
// are sticky levels, not pulses.
//
// fsm_state is a debug view of the verdict FSM:
// 0 = IDLE, 1 = RUN, 2 = PASS, 3 = FAIL.
interface mprj_checkpoint_monitor_if;
  logic        enable;
  logic [15:0] checkbits;
  logic        done;
  logic        pass;
  logic        fail;
  logic [2:0]  fail_cause;
  logic [7:0]  cur_group;
  logic [3:0]  pass_count;
  logic        code_valid;
  logic [15:0] code;
  logic [1:0]  fsm_state;

  // The harness side drives the raw checkpoint word and the enable.
  modport master (
    output enable, checkbits,
    input  done, pass, fail, fail_cause, cur_group, pass_count,
    input  code_valid, code, fsm_state
  );

  // The monitor side consumes the raw word and reports the verdict.
  modport slave (
    input  enable, checkbits,
    output done, pass, fail, fail_cause, cur_group, pass_count,
    output code_valid, code, fsm_state
  );
endinterface

// File: rtl/mprj_checkpoint_monitor.sv
// Firmware checkpoint monitor for mprj_io[31:16].
// Synchronizes and debounces the raw checkpoint word, decodes start/result
// codes, sequences test groups with an optional timeout and keeps a sticky
// pass/fail verdict until reset.
module mprj_checkpoint_monitor #(
  parameter int STABLE_CYCLES  = 4,
  parameter int NUM_GROUPS     = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  mprj_checkpoint_monitor_if.slave mon
);

  // Timer is at least 17 bits wide so the default timeout fits with headroom.
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW > 17) ? TW_RAW : 17;

  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX   = '1;
  localparam logic [3:0]    STABLE_LIM  = 4'(STABLE_CYCLES);
  localparam logic [3:0]    GROUPS_LIM  = 4'(NUM_GROUPS);
  localparam bit            TIMEOUT_ON  = (TIMEOUT_CYCLES != 0);

  localparam logic [2:0] CAUSE_NONE      = 3'd0;
  localparam logic [2:0] CAUSE_GROUPFAIL = 3'd1;
  localparam logic [2:0] CAUSE_TIMEOUT   = 3'd2;
  localparam logic [2:0] CAUSE_MISMATCH  = 3'd3;
  localparam logic [2:0] CAUSE_RESTART   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Input path: 2-flop synchronizer followed by a stability filter.
  // ------------------------------------------------------------------
  logic [15:0] sync1_q, sync1_d;
  logic [15:0] sync2_q, sync2_d;
  logic [15:0] last_q, last_d;     // sync2 one cycle ago, to detect changes
  logic [3:0]  held_q, held_d;     // cycles sync2 has held, saturating
  logic [15:0] code_q, code_d;
  logic        code_valid_q, code_valid_d;

  logic [3:0]  held_now;           // cycles held including the current one
  logic        accept;

  // Count how long the synchronized value has been steady and accept it
  // once it has held long enough and is new relative to the last code.
  always_comb begin
    sync1_d      = sync1_q;
    sync2_d      = sync2_q;
    last_d       = last_q;
    held_d       = held_q;
    code_d       = code_q;
    code_valid_d = 1'b0;

    if (sync2_q != last_q) begin
      held_now = 4'd1;
    end else if (held_q >= STABLE_LIM) begin
      held_now = STABLE_LIM;
    end else begin
      held_now = held_q + 4'd1;
    end

    accept = (held_now >= STABLE_LIM) && (sync2_q != code_q);

    // With enable low every filter register holds, so no pulse can form.
    if (mon.enable) begin
      sync1_d = mon.checkbits;
      sync2_d = sync1_q;
      last_d  = sync2_q;
      held_d  = held_now;
      if (accept) begin
        code_d       = sync2_q;
        code_valid_d = 1'b1;
      end
    end
  end

  // Filter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      last_q       <= '0;
      held_q       <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      last_q       <= last_d;
      held_q       <= held_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
    end
  end

  // ------------------------------------------------------------------
  // Decode of the registered filtered code.
  // ------------------------------------------------------------------
  logic       is_start;
  logic       is_result;
  logic       res_pass;
  logic [7:0] res_group;

  // START = A0 gg with even group, RESULT = AB rr; anything else is ignored.
  always_comb begin
    is_start  = code_valid_q && (code_q[15:8] == 8'hA0) && !code_q[0];
    is_result = code_valid_q && (code_q[15:8] == 8'hAB);
    res_pass  = code_q[0];
    res_group = {code_q[7:1], 1'b0};
  end

  // ------------------------------------------------------------------
  // Verdict FSM with registered outputs.
  // ------------------------------------------------------------------
  state_t      state_q;
  logic        done_q;
  logic        pass_q;
  logic        fail_q;
  logic [2:0]  fail_cause_q;
  logic [7:0]  cur_group_q;
  logic [3:0]  pass_count_q;
  logic [TW-1:0] timer_q;

  logic [TW-1:0] timer_inc;
  logic          timeout_hit;
  logic [3:0]    pass_inc;

  // Saturating next values for the timer and the pass counter.
  always_comb begin
    timer_inc   = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    timeout_hit = TIMEOUT_ON && mon.enable && (timer_inc == TIMEOUT_LIM);
    pass_inc    = (pass_count_q == 4'hF) ? 4'hF : pass_count_q + 4'd1;
  end

  // Group sequencing. A code_valid pulse only ever follows an enabled cycle,
  // so it is consumed even if enable drops on that cycle; otherwise the code
  // would be lost. The timer, which is what enable is meant to pause, is
  // gated by enable. A result beats a timeout landing on the same edge
  // because the result branch is checked first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_cause_q <= CAUSE_NONE;
      cur_group_q  <= '0;
      pass_count_q <= '0;
      timer_q      <= '0;
    end else begin
      if (mon.enable && (state_q == ST_RUN)) begin
        timer_q <= timer_inc;
      end

      case (state_q)
        ST_IDLE: begin
          if (is_start) begin
            state_q     <= ST_RUN;
            cur_group_q <= code_q[7:0];
            timer_q     <= '0;
          end else if (is_result) begin
            state_q      <= ST_FAIL;
            done_q       <= 1'b1;
            fail_q       <= 1'b1;
            fail_cause_q <= CAUSE_MISMATCH;
          end
        end

        ST_RUN: begin
          if (is_result) begin
            if (res_group != cur_group_q) begin
              state_q      <= ST_FAIL;
              done_q       <= 1'b1;
              fail_q       <= 1'b1;
              fail_cause_q <= CAUSE_MISMATCH;
            end else if (!res_pass) begin
              state_q      <= ST_FAIL;
              done_q       <= 1'b1;
              fail_q       <= 1'b1;
              fail_cause_q <= CAUSE_GROUPFAIL;
            end else begin
              pass_count_q <= pass_inc;
              if (pass_inc == GROUPS_LIM) begin
                state_q <= ST_PASS;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end else if (is_start) begin
            state_q      <= ST_FAIL;
            done_q       <= 1'b1;
            fail_q       <= 1'b1;
            fail_cause_q <= CAUSE_RESTART;
          end else if (timeout_hit) begin
            state_q      <= ST_FAIL;
            done_q       <= 1'b1;
            fail_q       <= 1'b1;
            fail_cause_q <= CAUSE_TIMEOUT;
          end
        end

        // PASS and FAIL are terminal until reset.
        default: begin
        end
      endcase
    end
  end

  // Output wiring.
  always_comb begin
    mon.done       = done_q;
    mon.pass       = pass_q;
    mon.fail       = fail_q;
    mon.fail_cause = fail_cause_q;
    mon.cur_group  = cur_group_q;
    mon.pass_count = pass_count_q;
    mon.code_valid = code_valid_q;
    mon.code       = code_q;
    mon.fsm_state  = state_q;
  end

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Self-checking bench for mprj_checkpoint_monitor (STABLE_CYCLES=4,
// NUM_GROUPS=3, TIMEOUT_CYCLES=50).
module tb_mprj_checkpoint_monitor;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam int         NGRP   = 3;

  logic clk;
  logic rst;

  mprj_checkpoint_monitor_if mon_if();

  mprj_checkpoint_monitor #(
    .STABLE_CYCLES (4),
    .NUM_GROUPS    (3),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clk),
    .reset(rst),
    .mon  (mon_if)
  );

  int n_checks;
  int n_fail;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  // One clock: sample #1 after the edge and collect any accepted code.
  task automatic step();
    @(posedge clk);
    #1;
    if (mon_if.code_valid === 1'b1) obs_q.push_back(mon_if.code);
  endtask

  task automatic set_hold(input logic [15:0] v, input int n);
    mon_if.checkbits = v;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_if.enable = 1'b1;
    mon_if.checkbits = 16'h0000;
    step();
    rst = 1'b0;
    obs_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Verdict from the ordered list of accepted codes, following the
  // group-sequencing rules (timeouts excluded: callers keep runs short).
  function automatic void model_verdict(input logic [15:0] acc[$],
                                        output logic m_done, output logic m_pass,
                                        output logic m_fail, output logic [2:0] m_cause,
                                        output logic [7:0] m_group, output logic [3:0] m_count);
    bit running;
    logic [15:0] c;
    bit st, rs;
    running = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_cause = 0; m_group = 0; m_count = 0;
    for (int i = 0; i < acc.size(); i++) begin
      c  = acc[i];
      st = (c[15:8] == 8'hA0) && (c[0] == 1'b0);
      rs = (c[15:8] == 8'hAB);
      if (m_done) continue;
      if (!running) begin
        if (st) begin
          running = 1; m_group = c[7:0];
        end else if (rs) begin
          m_done = 1; m_fail = 1; m_cause = 3;
        end
      end else begin
        if (rs) begin
          if ({c[7:1], 1'b0} != m_group) begin
            m_done = 1; m_fail = 1; m_cause = 3;
          end else if (c[0] == 1'b0) begin
            m_done = 1; m_fail = 1; m_cause = 1;
          end else begin
            m_count = m_count + 1;
            running = 0;
            if (m_count == NGRP) begin
              m_done = 1; m_pass = 1;
            end
          end
        end else if (st) begin
          m_done = 1; m_fail = 1; m_cause = 4;
        end
      end
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (mon_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", mon_if.done); end
    n_checks++; if (mon_if.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", mon_if.pass); end
    n_checks++; if (mon_if.fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", mon_if.fail); end
    n_checks++; if (mon_if.fail_cause !== 3'd0) begin n_fail++; $display("FAIL reset_cause: got %0d want 0", mon_if.fail_cause); end
    n_checks++; if (mon_if.cur_group !== 8'h00) begin n_fail++; $display("FAIL reset_group: got %h want 00", mon_if.cur_group); end
    n_checks++; if (mon_if.pass_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", mon_if.pass_count); end
    n_checks++; if (mon_if.code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cv: got %b want 0", mon_if.code_valid); end
    n_checks++; if (mon_if.code !== 16'h0000) begin n_fail++; $display("FAIL reset_code: got %h want 0000", mon_if.code); end
    n_checks++; if (mon_if.fsm_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", mon_if.fsm_state, S_IDLE); end
  endtask

  task automatic test_full_pass();
    logic [15:0] seq [6];
    seq[0] = 16'hA040; seq[1] = 16'hAB41; seq[2] = 16'hA020;
    seq[3] = 16'hAB21; seq[4] = 16'hA010; seq[5] = 16'hAB11;
    do_reset();
    for (int i = 0; i < 5; i++) set_hold(seq[i], 20);
    mon_if.checkbits = seq[5];
    repeat (6) step();
    n_checks++; if (mon_if.code_valid !== 1'b1) begin n_fail++; $display("FAIL pass_cv_latency: got %b want 1", mon_if.code_valid); end
    n_checks++; if (mon_if.done !== 1'b0) begin n_fail++; $display("FAIL pass_done_early: got %b want 0", mon_if.done); end
    step();
    n_checks++; if (mon_if.done !== 1'b1) begin n_fail++; $display("FAIL pass_done_next: got %b want 1", mon_if.done); end
    repeat (13) step();
    n_checks++; if (obs_q.size() !== 6) begin n_fail++; $display("FAIL pass_pulses: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== seq[i]) begin n_fail++; $display("FAIL pass_code%0d: got %h want %h", i, obs_q[i], seq[i]); end
    end
    n_checks++; if (mon_if.pass_count !== 4'd3) begin n_fail++; $display("FAIL pass_count: got %0d want 3", mon_if.pass_count); end
    n_checks++; if (mon_if.pass !== 1'b1) begin n_fail++; $display("FAIL pass_pass: got %b want 1", mon_if.pass); end
    n_checks++; if (mon_if.fail !== 1'b0) begin n_fail++; $display("FAIL pass_fail: got %b want 0", mon_if.fail); end
    // Terminal: a further failing result must not disturb the verdict.
    set_hold(16'hAB40, 20);
    n_checks++; if (mon_if.code !== 16'hAB40) begin n_fail++; $display("FAIL pass_code_after: got %h want AB40", mon_if.code); end
    n_checks++; if (mon_if.pass !== 1'b1 || mon_if.fail !== 1'b0) begin n_fail++; $display("FAIL pass_sticky: got pass=%b fail=%b want 1/0", mon_if.pass, mon_if.fail); end
  endtask

  task automatic test_group_fail();
    do_reset();
    set_hold(16'hA040, 20);
    set_hold(16'hAB40, 20);
    n_checks++; if (mon_if.fail !== 1'b1) begin n_fail++; $display("FAIL gfail_fail: got %b want 1", mon_if.fail); end
    n_checks++; if (mon_if.fail_cause !== 3'd1) begin n_fail++; $display("FAIL gfail_cause: got %0d want 1", mon_if.fail_cause); end
    n_checks++; if (mon_if.cur_group !== 8'h40) begin n_fail++; $display("FAIL gfail_group: got %h want 40", mon_if.cur_group); end
    n_checks++; if (mon_if.pass_count !== 4'd0) begin n_fail++; $display("FAIL gfail_count: got %0d want 0", mon_if.pass_count); end
    n_checks++; if (mon_if.pass !== 1'b0) begin n_fail++; $display("FAIL gfail_pass: got %b want 0", mon_if.pass); end
  endtask

  task automatic test_glitch();
    do_reset();
    set_hold(16'hA040, 3);
    set_hold(16'h0000, 20);
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL glitch3_pulses: got %0d want 0", obs_q.size()); end
    n_checks++; if (mon_if.fsm_state !== S_IDLE) begin n_fail++; $display("FAIL glitch3_state: got %0d want %0d", mon_if.fsm_state, S_IDLE); end
    // Exactly STABLE_CYCLES is enough.
    set_hold(16'hA040, 4);
    set_hold(16'h0000, 20);
    n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL glitch4_pulses: got %0d want 2", obs_q.size()); end
    n_checks++; if (mon_if.fsm_state !== S_RUN) begin n_fail++; $display("FAIL glitch4_state: got %0d want %0d", mon_if.fsm_state, S_RUN); end
  endtask

  task automatic test_timeout();
    int first;
    do_reset();
    first = -1;
    mon_if.checkbits = 16'hA020;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (first < 0 && mon_if.fail === 1'b1) first = k;
    end
    // code_valid after 6 edges, RUN after 7, timeout 50 cycles later.
    n_checks++; if (first !== 57) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 57", first); end
    n_checks++; if (mon_if.fail_cause !== 3'd2) begin n_fail++; $display("FAIL timeout_cause: got %0d want 2", mon_if.fail_cause); end
    n_checks++; if (mon_if.done !== 1'b1) begin n_fail++; $display("FAIL timeout_done: got %b want 1", mon_if.done); end
  endtask

  // Result applied `gap` cycles after the start: gap 50 lands on the
  // timeout edge itself (result wins), gap 51 one edge too late.
  task automatic test_timeout_vs_result(input int gap, input bit want_fail);
    do_reset();
    set_hold(16'hA020, gap);
    set_hold(16'hAB21, 20);
    n_checks++; if (mon_if.fail !== want_fail) begin n_fail++; $display("FAIL race%0d_fail: got %b want %b", gap, mon_if.fail, want_fail); end
    n_checks++; if (mon_if.pass_count !== (want_fail ? 4'd0 : 4'd1)) begin n_fail++; $display("FAIL race%0d_count: got %0d want %0d", gap, mon_if.pass_count, want_fail ? 0 : 1); end
    n_checks++; if (mon_if.fail_cause !== (want_fail ? 3'd2 : 3'd0)) begin n_fail++; $display("FAIL race%0d_cause: got %0d want %0d", gap, mon_if.fail_cause, want_fail ? 2 : 0); end
  endtask

  task automatic test_mismatch();
    do_reset();
    set_hold(16'hA040, 20);
    set_hold(16'hAB21, 20);
    n_checks++; if (mon_if.fail_cause !== 3'd3) begin n_fail++; $display("FAIL mm_wrong_group: got %0d want 3", mon_if.fail_cause); end
    do_reset();
    set_hold(16'hAB11, 20);
    n_checks++; if (mon_if.fail_cause !== 3'd3) begin n_fail++; $display("FAIL mm_result_idle: got %0d want 3", mon_if.fail_cause); end
    do_reset();
    set_hold(16'hA040, 20);
    set_hold(16'hA020, 20);
    n_checks++; if (mon_if.fail_cause !== 3'd4) begin n_fail++; $display("FAIL mm_restart: got %0d want 4", mon_if.fail_cause); end
    n_checks++; if (mon_if.fail !== 1'b1) begin n_fail++; $display("FAIL mm_restart_fail: got %b want 1", mon_if.fail); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    set_hold(16'hA040, 20);
    set_hold(16'hAB41, 20);
    n_checks++; if (mon_if.pass_count !== 4'd1) begin n_fail++; $display("FAIL mid_count_pre: got %0d want 1", mon_if.pass_count); end
    do_reset();
    n_checks++; if ({mon_if.done, mon_if.pass, mon_if.fail, mon_if.code_valid} !== 4'b0000) begin n_fail++; $display("FAIL mid_flags: got %b want 0000", {mon_if.done, mon_if.pass, mon_if.fail, mon_if.code_valid}); end
    n_checks++; if (mon_if.pass_count !== 4'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", mon_if.pass_count); end
    n_checks++; if (mon_if.code !== 16'h0000 || mon_if.cur_group !== 8'h00) begin n_fail++; $display("FAIL mid_code: got code=%h grp=%h want 0000/00", mon_if.code, mon_if.cur_group); end
    mon_if.enable = 1'b0;
    set_hold(16'hA020, 20);
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL en_pulses: got %0d want 0", obs_q.size()); end
    n_checks++; if (mon_if.fsm_state !== S_IDLE) begin n_fail++; $display("FAIL en_state: got %0d want %0d", mon_if.fsm_state, S_IDLE); end
    mon_if.enable = 1'b1;
    repeat (6) step();
    n_checks++; if (mon_if.code_valid !== 1'b1 || mon_if.code !== 16'hA020) begin n_fail++; $display("FAIL en_resume: got cv=%b code=%h want 1/A020", mon_if.code_valid, mon_if.code); end
    step();
    n_checks++; if (mon_if.fsm_state !== S_RUN) begin n_fail++; $display("FAIL en_run: got %0d want %0d", mon_if.fsm_state, S_RUN); end
  endtask

  task automatic test_random_filter();
    logic [15:0] last_acc, prev_raw, v;
    int h;
    do_reset();
    exp_q.delete();
    last_acc = 16'h0000;
    prev_raw = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      do begin
        v = ($urandom_range(0, 3) == 0) ? last_acc : 16'($urandom_range(0, 65535));
      end while (v == prev_raw);
      h = $urandom_range(1, 7);
      if (h >= 4 && v != last_acc) begin
        exp_q.push_back(v);
        last_acc = v;
      end
      set_hold(v, h);
      prev_raw = v;
    end
    if (last_acc == prev_raw) set_hold(last_acc, 10);
    else begin
      set_hold(last_acc, 10);
    end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rfilt_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rfilt_code%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_sequences();
    logic [15:0] codes[$];
    logic [15:0] last, c;
    logic [7:0]  grp;
    int n;
    logic m_done, m_pass, m_fail;
    logic [2:0] m_cause;
    logic [7:0] m_group;
    logic [3:0] m_count;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      codes.delete();
      exp_q.delete();
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0:       grp = 8'h10;
          1:       grp = 8'h20;
          default: grp = 8'h40;
        endcase
        case ($urandom_range(0, 4))
          0, 1:    c = {8'hA0, grp};
          2:       c = {8'hAB, grp | 8'h01};
          3:       c = {8'hAB, grp | 8'($urandom_range(0, 1))};
          default: c = 16'($urandom_range(0, 65535));
        endcase
        codes.push_back(c);
      end
      last = 16'h0000;
      for (int i = 0; i < n; i++) begin
        if (codes[i] != last) begin
          exp_q.push_back(codes[i]);
          last = codes[i];
        end
      end
      for (int i = 0; i < n; i++) set_hold(codes[i], 7);
      set_hold(codes[n-1], 8);
      model_verdict(exp_q, m_done, m_pass, m_fail, m_cause, m_group, m_count);
      n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rseq%0d_pulses: got %0d want %0d", it, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rseq%0d_code%0d: got %h want %h", it, i, obs_q[i], exp_q[i]); end
      end
      n_checks++;
      if ({mon_if.done, mon_if.pass, mon_if.fail, mon_if.fail_cause} !== {m_done, m_pass, m_fail, m_cause}) begin
        n_fail++;
        $display("FAIL rseq%0d_verdict: got d/p/f/c=%b%b%b/%0d want %b%b%b/%0d", it,
                 mon_if.done, mon_if.pass, mon_if.fail, mon_if.fail_cause, m_done, m_pass, m_fail, m_cause);
      end
      n_checks++; if (mon_if.pass_count !== m_count) begin n_fail++; $display("FAIL rseq%0d_count: got %0d want %0d", it, mon_if.pass_count, m_count); end
      n_checks++; if (mon_if.cur_group !== m_group) begin n_fail++; $display("FAIL rseq%0d_group: got %h want %h", it, mon_if.cur_group, m_group); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    mon_if.enable = 1'b1;
    mon_if.checkbits = 16'h0000;
    test_reset();
    test_full_pass();
    test_group_fail();
    test_glitch();
    test_timeout();
    test_timeout_vs_result(50, 1'b0);
    test_timeout_vs_result(51, 1'b1);
    test_mismatch();
    test_reset_midrun();
    test_random_filter();
    test_random_sequences();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
